// File: rtl/divide_image.sv
// divide_image: sequential signed restoring divider, one quotient bit per cycle; DIV_IMAGE_EN adds den_image quotient negation
module divide_image #(
  parameter int A_WIDTH = 6,
  parameter int B_WIDTH = 6
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] in_A,
  input  logic [B_WIDTH-1:0] in_B,
`ifdef DIV_IMAGE_EN
  input  logic               den_image,
`endif
  output logic [A_WIDTH-1:0] out_Q,
  output logic [B_WIDTH-1:0] out_R,
  output logic               out_div_zero,
  output logic               out_ovf,
  output logic               out_valid,
  input  logic               out_ready
);
  localparam int CW = (A_WIDTH > 1) ? $clog2(A_WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [A_WIDTH-1:0] a_mag_q, a_mag_d;
  logic [B_WIDTH-1:0] b_mag_q, b_mag_d;
  logic [B_WIDTH-1:0] rem_q, rem_d;
  logic [B_WIDTH-1:0] a_low_q, a_low_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic               dz_q, dz_d, ovf_q, ovf_d, img_q, img_d;
  logic [A_WIDTH-1:0] out_q_q, out_q_d;
  logic [B_WIDTH-1:0] out_r_q, out_r_d;
  logic               out_dz_q, out_dz_d, out_ovf_q, out_ovf_d;
  logic [B_WIDTH:0]   rem_sh;
  logic               keep;
  logic [A_WIDTH-1:0] q_sgn;
  logic [B_WIDTH-1:0] r_sgn;
  logic               img_in;
`ifdef DIV_IMAGE_EN
  assign img_in = den_image;
`else
  assign img_in = 1'b0;
`endif
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      rem_q    <= '0;
      a_low_q  <= '0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      img_q    <= 1'b0;
      out_q_q  <= '0;
      out_r_q  <= '0;
      out_dz_q <= 1'b0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      rem_q    <= rem_d;
      a_low_q  <= a_low_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      img_q    <= img_d;
      out_q_q  <= out_q_d;
      out_r_q  <= out_r_d;
      out_dz_q <= out_dz_d;
      out_ovf_q <= out_ovf_d;
    end
  end
  // next state: fixed-length iteration regardless of operands
  always_comb begin
    state_d = state_q == IDLE ? (in_valid ? BUSY : IDLE) :
              state_q == BUSY ? (cnt_q == CW'(A_WIDTH - 1) ? FIX : BUSY) :
              state_q == FIX  ? DONE :
              (out_ready ? IDLE : DONE);
  end
  // handshake outputs decoded from state
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
  end
  // datapath: capture magnitudes, restoring iterations, then sign correction
  always_comb begin
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    rem_d     = rem_q;
    a_low_d   = a_low_q;
    cnt_d     = cnt_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    img_d     = img_q;
    out_q_d   = out_q_q;
    out_r_d   = out_r_q;
    out_dz_d  = out_dz_q;
    out_ovf_d = out_ovf_q;
    rem_sh    = {rem_q, a_mag_q[A_WIDTH-1]};
    keep      = rem_sh >= {1'b0, b_mag_q};
    q_sgn     = (sign_a_q ^ sign_b_q ^ img_q) ? ~a_mag_q + A_WIDTH'(1) : a_mag_q;
    r_sgn     = sign_a_q ? ~rem_q + B_WIDTH'(1) : rem_q;
    if (state_q == IDLE && in_valid) begin
      a_mag_d  = in_A[A_WIDTH-1] ? ~in_A + A_WIDTH'(1) : in_A;
      b_mag_d  = in_B[B_WIDTH-1] ? ~in_B + B_WIDTH'(1) : in_B;
      sign_a_d = in_A[A_WIDTH-1];
      sign_b_d = in_B[B_WIDTH-1];
      dz_d     = in_B == '0;
      ovf_d    = in_A == {1'b1, {(A_WIDTH-1){1'b0}}} && in_B == {B_WIDTH{1'b1}};
      img_d    = img_in;
      a_low_d  = in_A[B_WIDTH-1:0];
      rem_d    = '0;
      cnt_d    = '0;
    end
    if (state_q == BUSY) begin
      rem_d   = keep ? rem_sh[B_WIDTH-1:0] - b_mag_q : rem_sh[B_WIDTH-1:0];
      a_mag_d = {a_mag_q[A_WIDTH-2:0], keep};
      cnt_d   = cnt_q + CW'(1);
    end
    if (state_q == FIX) begin
      out_q_d   = ovf_q ? {1'b1, {(A_WIDTH-1){1'b0}}} : dz_q ? {A_WIDTH{1'b1}} : q_sgn;
      out_r_d   = ovf_q ? '0 : dz_q ? a_low_q : r_sgn;
      out_dz_d  = dz_q;
      out_ovf_d = ovf_q;
    end
  end
  assign out_Q        = out_q_q;
  assign out_R        = out_r_q;
  assign out_div_zero = out_dz_q;
  assign out_ovf      = out_ovf_q;
endmodule

// File: tb/tb_divide_image.sv
// tb_divide_image: scoreboard bench for divide_image (image cases under DIV_IMAGE_EN)
module tb_divide_image;
  localparam int AW = 6;
  localparam int BW = 6;
  typedef struct {
    logic [AW-1:0] q;
    logic [BW-1:0] r;
    logic          dz;
    logic          ovf;
  } exp_t;
  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_A = '0;
  logic [BW-1:0] in_B = '0;
  logic          den_image = 1'b0;
  logic [AW-1:0] out_Q;
  logic [BW-1:0] out_R;
  logic          out_div_zero;
  logic          out_ovf;
  logic          out_valid;
  logic          out_ready = 1'b0;
  exp_t          sb[$];
  int            n_chk = 0;
  int            n_pass = 0;
  divide_image #(.A_WIDTH(AW), .B_WIDTH(BW)) dut (
    .clk(clk),
    .resetn(resetn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_A(in_A),
    .in_B(in_B),
`ifdef DIV_IMAGE_EN
    .den_image(den_image),
`endif
    .out_Q(out_Q),
    .out_R(out_R),
    .out_div_zero(out_div_zero),
    .out_ovf(out_ovf),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic exp_t model(input int a, input int b, input bit img);
    exp_t e;
    int q, r;
    q = 0;
    r = 0;
    e.dz = 1'b0;
    e.ovf = 1'b0;
    if (b == 0) begin
      q = -1;
      r = a;
      e.dz = 1'b1;
    end else if (a == -(1 << (AW - 1)) && b == -1) begin
      q = a;
      e.ovf = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      if (img) q = -q;
    end
    e.q = q[AW-1:0];
    e.r = r[BW-1:0];
    return e;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input int a, input int b, input bit img, input int hold);
    int lat;
    int w;
    exp_t e;
    sb.push_back(model(a, b, img));
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    if (w == 50) check("ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_A = a[AW-1:0];
    in_B = b[BW-1:0];
    den_image = img;
    tick();
    in_valid = 1'b0;
    lat = 1;
    check("busy_ready", in_ready, 0);
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", lat, AW + 2);
    e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_A = 6'd9;
      in_B = 6'd2;
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
      check("hold_q", out_Q, e.q);
      check("hold_r", out_R, e.r);
      tick();
    end
    in_valid = 1'b0;
    check("q", out_Q, e.q);
    check("r", out_R, e.r);
    check("dz", out_div_zero, e.dz);
    check("ovf", out_ovf, e.ovf);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_ready", in_ready, 1);
  endtask
  initial begin
    repeat (3) tick();
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_q", out_Q, 0);
    check("rst_r", out_R, 0);
    check("rst_dz", out_div_zero, 0);
    check("rst_ovf", out_ovf, 0);
    resetn = 1'b1;
    tick();
    run_op(23, 5, 1'b0, 0);
    run_op(-23, 5, 1'b0, 0);
    run_op(23, -5, 1'b0, 0);
    run_op(-23, -5, 1'b0, 0);
    run_op(-32, -1, 1'b0, 0);
    run_op(7, 0, 1'b0, 0);
    run_op(-32, 0, 1'b0, 0);
    run_op(31, -32, 1'b0, 0);
    run_op(-32, -32, 1'b0, 0);
    run_op(17, 4, 1'b0, 10);
    run_op(-9, 2, 1'b0, 0);
    in_valid = 1'b1;
    in_A = 6'd13;
    in_B = 6'd3;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    resetn = 1'b0;
    #1;
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_q", out_Q, 0);
    check("mid_rst_r", out_R, 0);
    tick();
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("no_pulse", out_valid, 0);
      tick();
    end
    run_op(20, 3, 1'b0, 0);
`ifdef DIV_IMAGE_EN
    run_op(20, 3, 1'b1, 0);
    run_op(-32, -1, 1'b1, 0);
    run_op(-23, 5, 1'b1, 0);
`endif
    for (int i = 0; i < 20; i++) begin
      int a, b;
      a = int'($urandom_range(0, 63)) - 32;
      b = int'($urandom_range(0, 63)) - 32;
`ifdef DIV_IMAGE_EN
      run_op(a, b, 1'($urandom_range(0, 1)), 0);
`else
      run_op(a, b, 1'b0, 0);
`endif
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
